// File: rtl/aidc_lite_comp_drain.sv
// Purpose: ping-pong buffer holding ZRLE-encoded blocks (up to DEPTH x 64b + size) for 32b engine readback.
// Latency: comp_rdata_o/comp_last_o registered, 1 cycle after an accepted comp_rden_i; one word per cycle.
// Backpressure: wr_ready_o drops while the write bank is FULL/DRAIN; writes then are dropped and flag ovf_o.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   valid_i/addr_i/data_i       encoded word write into the current write bank
//   blk_valid_i/blk_size_i      block-complete pulse with block size in bits
//   wr_ready_o                  write bank can accept words / block completion
//   comp_ready_o/comp_size_o    a complete block is at the read head, and its size
//   comp_rden_i                 pop one 32b word
//   comp_rdata_o/comp_last_o    read data and final-word qualifier
//   ovf_o, err_o                sticky overflow and illegal-size flags
module aidc_lite_comp_drain #(
  parameter int DEPTH    = 16,
  parameter int MAX_BITS = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = $clog2(MAX_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   data_i,
  input  logic          blk_valid_i,
  input  logic [SW-1:0] blk_size_i,
  output logic          wr_ready_o,
  output logic          comp_ready_o,
  output logic [SW-1:0] comp_size_o,
  input  logic          comp_rden_i,
  output logic [31:0]   comp_rdata_o,
  output logic          comp_last_o,
  output logic          ovf_o,
  output logic          err_o
);

  // 32b read pointer covers two half-words per 64b storage word
  localparam int RW = $clog2(DEPTH * 2);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    DRAIN   = 2'd3
  } bank_st_t;

  bank_st_t        st     [2];
  logic [SW-1:0]   size_q [2];
  logic [63:0]     mem    [2][DEPTH];
  logic            wr_bank;
  logic            rd_bank;
  logic [RW-1:0]   rd_ptr;

  logic            size_bad;
  logic            rd_fire;
  logic [SW-1:0]   rd_size;
  logic [SW:0]     sz_rnd;
  logic [SW:0]     n_m1;
  logic            is_last;
  logic [4:0]      rem;
  logic [31:0]     mask;
  logic [63:0]     word64;
  logic [31:0]     half;
  logic [31:0]     rd_word;

  // The read bank is always FULL/DRAIN when active, the write bank EMPTY/FILLING,
  // so the two sides never update the same bank in one cycle.
  assign wr_ready_o   = (st[wr_bank] == EMPTY) || (st[wr_bank] == FILLING);
  assign comp_ready_o = (st[rd_bank] == FULL) || (st[rd_bank] == DRAIN);
  assign comp_size_o  = comp_ready_o ? size_q[rd_bank] : '0;

  assign size_bad = (blk_size_i == '0) || (blk_size_i > SW'(MAX_BITS));
  assign rd_fire  = comp_rden_i && comp_ready_o;

  // Word count minus one = ceil(size/32) - 1
  assign rd_size = size_q[rd_bank];
  assign sz_rnd  = {1'b0, rd_size} + (SW+1)'(31);
  assign n_m1    = (sz_rnd >> 5) - (SW+1)'(1);
  assign is_last = ({{(SW+1-RW){1'b0}}, rd_ptr} == n_m1);

  // Bits of the final word at or above size are forced to zero
  assign rem  = rd_size[4:0];
  assign mask = (rem == 5'd0) ? '1 : ((32'd1 << rem) - 32'd1);

  assign word64  = mem[rd_bank][rd_ptr[RW-1:1]];
  assign half    = rd_ptr[0] ? word64[63:32] : word64[31:0];
  assign rd_word = is_last ? (half & mask) : half;

  // Storage carries no reset; bank state alone decides what is valid
  always_ff @(posedge clk) begin
    if (valid_i && wr_ready_o) begin
      mem[wr_bank][addr_i] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st[0]        <= EMPTY;
      st[1]        <= EMPTY;
      size_q[0]    <= '0;
      size_q[1]    <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      rd_ptr       <= '0;
      comp_rdata_o <= '0;
      comp_last_o  <= 1'b0;
      ovf_o        <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      if ((valid_i || blk_valid_i) && !wr_ready_o) begin
        ovf_o <= 1'b1;
      end

      if (wr_ready_o) begin
        if (blk_valid_i) begin
          if (size_bad) begin
            err_o       <= 1'b1;
            st[wr_bank] <= EMPTY;
          end else begin
            size_q[wr_bank] <= blk_size_i;
            st[wr_bank]     <= FULL;
            wr_bank         <= ~wr_bank;
          end
        end else if (valid_i) begin
          st[wr_bank] <= FILLING;
        end
      end

      if (rd_fire) begin
        comp_rdata_o <= rd_word;
        comp_last_o  <= is_last;
        if (is_last) begin
          st[rd_bank] <= EMPTY;
          rd_bank     <= ~rd_bank;
          rd_ptr      <= '0;
        end else begin
          st[rd_bank] <= DRAIN;
          rd_ptr      <= rd_ptr + RW'(1);
        end
      end
    end
  end

endmodule
